wb_result_stage: RTL and testbench

- Registered write-back stage; the parametrised successor to the combinational write-back result mux.
- Selects among ALU, load, PC+4 and immediate results, then registers the register-file write port.
- Waits for variable-latency data-memory read returns, with a valid/ready stall.
- Aligns and sign- or zero-extends sub-word loads, and flags loads that never return.

---
 rtl/wb_result_stage.sv | 184 ++++++++++++++++++
 tb/tb_wb_result_stage.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_result_stage.sv
// Registered write-back stage: result select, sub-word load alignment and a
// valid/ready stall for variable-latency loads. Optional macro: WB_FWD_EN.
//
// state       | meaning
// ------------+--------------------------------------------------------
// S_IDLE      | accepting; non-loads write back one cycle after accept
// S_LOAD_WAIT | load issued, stalled until mem_rvalid or timeout
module wb_result_stage #(
    parameter int WIDTH          = 32,
    parameter int REG_ADDR_W     = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_result_src,
    input  logic [WIDTH-1:0]      in_alu_result,
    input  logic [WIDTH-1:0]      in_pc_plus4,
    input  logic [WIDTH-1:0]      in_imm,
    input  logic [2:0]            in_funct3,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_reg_write,
    input  logic                  mem_rvalid,
    input  logic [WIDTH-1:0]      mem_rdata,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [WIDTH-1:0]      rf_wdata,
    output logic                  load_pending,
    output logic                  load_timeout
`ifdef WB_FWD_EN
    ,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_rd,
    output logic [WIDTH-1:0]      fwd_data
`endif
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic {
        S_IDLE      = 1'b0,
        S_LOAD_WAIT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
    logic                    rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
    logic [WIDTH-1:0]        rf_wdata_q, rf_wdata_d;
    logic                    load_timeout_q, load_timeout_d;
    logic [REG_ADDR_W-1:0]   ld_rd_q, ld_rd_d;
    logic                    ld_rw_q, ld_rw_d;
    logic [2:0]              ld_f3_q, ld_f3_d;
    logic [1:0]              ld_off_q, ld_off_d;

    logic [WIDTH-1:0]        sel_data;
    logic [31:0]             ld_word;
    logic [7:0]              ld_byte;
    logic [15:0]             ld_half;
    logic [WIDTH-1:0]        ld_data;

    always_comb begin
        sel_data = in_alu_result;
        case (in_result_src)
            2'b10:   sel_data = in_pc_plus4;
            2'b11:   sel_data = in_imm;
            default: sel_data = in_alu_result;
        endcase
    end

    // Load lanes always come from the low 32 bits of the returned data.
    always_comb begin
        ld_word = mem_rdata[31:0];
        ld_byte = ld_word[7:0];
        case (ld_off_q)
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            2'd3:    ld_byte = ld_word[31:24];
            default: ld_byte = ld_word[7:0];
        endcase
        ld_half = ld_off_q[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_f3_q)
            3'b000:  ld_data = WIDTH'($signed(ld_byte));
            3'b001:  ld_data = WIDTH'($signed(ld_half));
            3'b100:  ld_data = WIDTH'(ld_byte);
            3'b101:  ld_data = WIDTH'(ld_half);
            default: ld_data = WIDTH'($signed(ld_word));
        endcase
    end

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rf_we_d        = 1'b0;
        rf_waddr_d     = rf_waddr_q;
        rf_wdata_d     = rf_wdata_q;
        load_timeout_d = load_timeout_q;
        ld_rd_d        = ld_rd_q;
        ld_rw_d        = ld_rw_q;
        ld_f3_d        = ld_f3_q;
        ld_off_d       = ld_off_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (in_result_src == 2'b01) begin
                        ld_rd_d  = in_rd;
                        ld_rw_d  = in_reg_write;
                        ld_f3_d  = in_funct3;
                        ld_off_d = in_alu_result[1:0];
                        cnt_d    = '0;
                        state_d  = S_LOAD_WAIT;
                    end else begin
                        rf_we_d    = in_reg_write && (in_rd != '0);
                        rf_waddr_d = in_rd;
                        rf_wdata_d = sel_data;
                    end
                end
            end
            S_LOAD_WAIT: begin
                if (mem_rvalid) begin
                    rf_we_d    = ld_rw_q && (ld_rd_q != '0);
                    rf_waddr_d = ld_rd_q;
                    rf_wdata_d = ld_data;
                    cnt_d      = '0;
                    state_d    = S_IDLE;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_inc == TIMEOUT_VAL)) begin
                    // Abandon the load; a late return lands in IDLE and is dropped.
                    load_timeout_d = 1'b1;
                    cnt_d          = '0;
                    state_d        = S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            rf_we_q        <= 1'b0;
            rf_waddr_q     <= '0;
            rf_wdata_q     <= '0;
            load_timeout_q <= 1'b0;
            ld_rd_q        <= '0;
            ld_rw_q        <= 1'b0;
            ld_f3_q        <= '0;
            ld_off_q       <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rf_we_q        <= rf_we_d;
            rf_waddr_q     <= rf_waddr_d;
            rf_wdata_q     <= rf_wdata_d;
            load_timeout_q <= load_timeout_d;
            ld_rd_q        <= ld_rd_d;
            ld_rw_q        <= ld_rw_d;
            ld_f3_q        <= ld_f3_d;
            ld_off_q       <= ld_off_d;
        end
    end

    assign in_ready     = (state_q == S_IDLE);
    assign load_pending = (state_q == S_LOAD_WAIT);
    assign rf_we        = rf_we_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign load_timeout = load_timeout_q;

`ifdef WB_FWD_EN
    // The forward view is exactly the write about to be registered.
    assign fwd_valid = rf_we_d && rst_n;
    assign fwd_rd    = rf_waddr_d;
    assign fwd_data  = rf_wdata_d;
`endif

endmodule

// File: tb/tb_wb_result_stage.sv
// Scoreboard bench for wb_result_stage: expected writes are queued when
// stimulus is driven and matched (data, address, cycle) when rf_we pulses.
module tb_wb_result_stage;

    localparam int W  = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_result_src;
    logic [W-1:0]  in_alu_result;
    logic [W-1:0]  in_pc_plus4;
    logic [W-1:0]  in_imm;
    logic [2:0]    in_funct3;
    logic [AW-1:0] in_rd;
    logic          in_reg_write;
    logic          mem_rvalid;
    logic [W-1:0]  mem_rdata;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [W-1:0]  rf_wdata;
    logic          load_pending;
    logic          load_timeout;
`ifdef WB_FWD_EN
    logic          fwd_valid;
    logic [AW-1:0] fwd_rd;
    logic [W-1:0]  fwd_data;
`endif

    wb_result_stage #(
        .WIDTH(W),
        .REG_ADDR_W(AW),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_result_src(in_result_src),
        .in_alu_result(in_alu_result),
        .in_pc_plus4(in_pc_plus4),
        .in_imm(in_imm),
        .in_funct3(in_funct3),
        .in_rd(in_rd),
        .in_reg_write(in_reg_write),
        .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata),
        .rf_we(rf_we),
        .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata),
        .load_pending(load_pending),
        .load_timeout(load_timeout)
`ifdef WB_FWD_EN
        ,
        .fwd_valid(fwd_valid),
        .fwd_rd(fwd_rd),
        .fwd_data(fwd_data)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = w >> (8 * off);
        h = w >> (16 * off[1]);
        case (f3)
            3'b000:  return {{24{b[7]}}, b[7:0]};
            3'b001:  return {{16{h[15]}}, h[15:0]};
            3'b100:  return {24'h0, b[7:0]};
            3'b101:  return {16'h0, h[15:0]};
            default: return w;
        endcase
    endfunction

    always begin
        @(posedge clk);
        #1;
        if (rst_n && rf_we) begin
            if (sb.size() == 0) begin
                check_val("unexpected_we", {59'd0, rf_waddr}, 64'h3f);
            end else begin
                mon_e = sb.pop_front();
                check_val("we_cycle", 64'(mon_e.cyc), 64'(cyc));
                check_val("waddr", 64'(rf_waddr), 64'(mon_e.addr));
                check_val("wdata", 64'(rf_wdata), 64'(mon_e.data));
            end
        end
    end

    task automatic push_exp(input logic [AW-1:0] a, input logic [W-1:0] d);
        exp_t e;
        e.cyc  = cyc + 1;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic idle_in();
        in_valid      = 1'b0;
        in_result_src = 2'b00;
        in_alu_result = 32'h5555_5555;
        in_pc_plus4   = 32'h6666_6666;
        in_imm        = 32'h7777_7777;
        in_funct3     = 3'b000;
        in_rd         = '0;
        in_reg_write  = 1'b0;
    endtask

    // Non-selected sources carry distinct junk so a wrong mux leg shows up.
    task automatic issue_op(input logic [1:0] src, input logic [W-1:0] val,
                            input logic [AW-1:0] rd, input logic rw);
        idle_in();
        in_valid      = 1'b1;
        in_result_src = src;
        in_rd         = rd;
        in_reg_write  = rw;
        case (src)
            2'b10:   in_pc_plus4   = val;
            2'b11:   in_imm        = val;
            default: in_alu_result = val;
        endcase
        if (rw && rd != '0) push_exp(rd, val);
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rdata,
                           input logic [AW-1:0] rd, input logic rw, input int dly);
        idle_in();
        in_valid      = 1'b1;
        in_result_src = 2'b01;
        in_alu_result = {30'h0000_0400, off};
        in_funct3     = f3;
        in_rd         = rd;
        in_reg_write  = rw;
        @(negedge clk);
        // A competing non-load is offered throughout the stall and must be refused.
        issue_op(2'b00, 32'hBAD0_0000, 5'd20, 1'b1);
        void'(sb.pop_back());
        mem_rdata = 32'h0BAD_F00D;
        for (int i = 0; i < dly; i++) begin
            check_val("stall_ready", 64'(in_ready), 64'd0);
            check_val("stall_pending", 64'(load_pending), 64'd1);
            if (i == dly - 1) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rdata;
                if (rw && rd != '0) push_exp(rd, ld_model(f3, off, rdata));
`ifdef WB_FWD_EN
                #1;
                check_val("fwd_valid", 64'(fwd_valid), 64'(rw && rd != '0));
                if (rw && rd != '0) begin
                    check_val("fwd_rd", 64'(fwd_rd), 64'(rd));
                    check_val("fwd_data", 64'(fwd_data), 64'(ld_model(f3, off, rdata)));
                end
`endif
            end
            @(negedge clk);
        end
        mem_rvalid = 1'b0;
        idle_in();
        check_val("ready_after_load", 64'(in_ready), 64'd1);
        check_val("pending_after_load", 64'(load_pending), 64'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        idle_in();
        repeat (2) @(negedge clk);
        check_val("rst_ready", 64'(in_ready), 64'd1);
        check_val("rst_we", 64'(rf_we), 64'd0);
        check_val("rst_waddr", 64'(rf_waddr), 64'd0);
        check_val("rst_wdata", 64'(rf_wdata), 64'd0);
        check_val("rst_pending", 64'(load_pending), 64'd0);
        check_val("rst_timeout", 64'(load_timeout), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue_op(2'b00, 32'h0000_1234, 5'd5, 1'b1);
`ifdef WB_FWD_EN
        #1;
        check_val("fwd_alu_valid", 64'(fwd_valid), 64'd1);
        check_val("fwd_alu_data", 64'(fwd_data), 64'h1234);
`endif
        @(negedge clk);
        idle_in();
        check_val("alu_ready", 64'(in_ready), 64'd1);

        issue_op(2'b10, 32'h0000_0100, 5'd4, 1'b1);
        @(negedge clk);
        issue_op(2'b11, 32'hABCD_0000, 5'd3, 1'b1);
        @(negedge clk);
        issue_op(2'b00, 32'h0000_0042, 5'd0, 1'b1);
        @(negedge clk);
        issue_op(2'b00, 32'h0000_0043, 5'd6, 1'b0);
        @(negedge clk);
        idle_in();
        @(negedge clk);
        check_val("idle_we", 64'(rf_we), 64'd0);

        do_load(3'b000, 2'd3, 32'h80FF_FFFF, 5'd7,  1'b1, 4);
        do_load(3'b100, 2'd3, 32'h80FF_FFFF, 5'd7,  1'b1, 1);
        do_load(3'b101, 2'd2, 32'h80FF_FFFF, 5'd11, 1'b1, 2);
        do_load(3'b001, 2'd3, 32'h8001_7F00, 5'd12, 1'b1, 1);
        do_load(3'b001, 2'd0, 32'h1234_F00D, 5'd16, 1'b1, 3);
        do_load(3'b101, 2'd0, 32'h1234_F00D, 5'd17, 1'b1, 1);
        do_load(3'b010, 2'd0, 32'h1234_5678, 5'd9,  1'b1, 1);
        do_load(3'b000, 2'd1, 32'h0000_7F00, 5'd13, 1'b1, 2);
        do_load(3'b111, 2'd2, 32'hDEAD_BEEF, 5'd14, 1'b1, 1);
        do_load(3'b010, 2'd0, 32'hCAFE_F00D, 5'd0,  1'b1, 1);
        do_load(3'b100, 2'd0, 32'hCAFE_F00D, 5'd15, 1'b0, 1);
        issue_op(2'b00, 32'h0000_0099, 5'd21, 1'b1);
        @(negedge clk);
        idle_in();

        in_valid      = 1'b1;
        in_result_src = 2'b01;
        in_rd         = 5'd8;
        in_reg_write  = 1'b1;
        @(negedge clk);
        idle_in();
        for (int i = 0; i < 4; i++) begin
            check_val("to_pending", 64'(load_pending), 64'd1);
            check_val("to_not_yet", 64'(load_timeout), 64'd0);
            @(negedge clk);
        end
        check_val("to_flag", 64'(load_timeout), 64'd1);
        check_val("to_ready", 64'(in_ready), 64'd1);
        check_val("to_pending_clr", 64'(load_pending), 64'd0);
        check_val("to_no_we", 64'(rf_we), 64'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_2222;
        @(negedge clk);
        mem_rvalid = 1'b0;
        @(negedge clk);
        check_val("to_sticky", 64'(load_timeout), 64'd1);
        check_val("late_ready", 64'(in_ready), 64'd1);
        issue_op(2'b11, 32'h0F0F_0000, 5'd22, 1'b1);
        @(negedge clk);
        idle_in();

        in_valid      = 1'b1;
        in_result_src = 2'b01;
        in_rd         = 5'd10;
        in_reg_write  = 1'b1;
        @(negedge clk);
        idle_in();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("mid_rst_pending", 64'(load_pending), 64'd0);
        check_val("mid_rst_timeout", 64'(load_timeout), 64'd0);
`ifdef WB_FWD_EN
        check_val("mid_rst_fwd", 64'(fwd_valid), 64'd0);
`endif
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h7654_3210;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check_val("post_rst_we", 64'(rf_we), 64'd0);
        check_val("post_rst_waddr", 64'(rf_waddr), 64'd0);
        check_val("post_rst_wdata", 64'(rf_wdata), 64'd0);
        check_val("post_rst_ready", 64'(in_ready), 64'd1);
        check_val("post_rst_pending", 64'(load_pending), 64'd0);

        repeat (3) @(negedge clk);
        check_val("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
